iter_shift_unit: RTL and testbench

- Parametrised, multi-cycle shift engine; successor to the single-cycle combinational right-shift submodule.
- Supports four shift modes with a valid/ready handshake on both sides.
- Shifts one bit position per clock and produces the same 4-bit status word as the existing ALU submodules.
- Sits between the ALU operand registers and the result mux.

---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_status_calc.sv | 17 +
 rtl/iter_shift_unit.sv | 141 ++++++++++++++
 tb/tb_iter_shift_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and status-word layout for the iterative shift engine and its ALU siblings.
package shift_pkg;

  typedef enum logic [1:0] {
    LSR = 2'b00,
    ASR = 2'b01,
    LSL = 2'b10,
    ROR = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

  localparam int ST_NEG   = 0;
  localparam int ST_PAR   = 1;
  localparam int ST_ONES  = 2;
  localparam int ST_RANGE = 3;

  // Assembles the 4-bit status word so every producer places flags identically.
  function automatic logic [3:0] pack_status(input logic neg, input logic par,
                                             input logic ones, input logic range);
    logic [3:0] s;
    s           = '0;
    s[ST_NEG]   = neg;
    s[ST_PAR]   = par;
    s[ST_ONES]  = ones;
    s[ST_RANGE] = range;
    return s;
  endfunction

endpackage

// File: rtl/shift_status_calc.sv
// Result-derived status flags (even nonzero popcount, all ones); purely combinational.
module shift_status_calc
  import shift_pkg::*;
#(
  parameter int M = 8
) (
  input  logic [M-1:0] result,
  output logic [2:1]   flags
);

  always_comb begin
    flags          = '0;
    flags[ST_PAR]  = ~(^result) & (|result);
    flags[ST_ONES] = &result;
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter, one bit position per clock, valid/ready on both sides.
// Optional operand inversion (port i_inv) is enabled by defining ITER_SHIFT_INVERT_EN.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int M  = 8,
  parameter int CW = $clog2(M) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [M-1:0]  i_arg_A,
  input  logic [M-1:0]  i_arg_B,
  input  logic [1:0]    i_mode,
`ifdef ITER_SHIFT_INVERT_EN
  input  logic          i_inv,
`endif
  output logic          o_valid,
  input  logic          i_ready,
  output logic [M-1:0]  o_newA,
  output logic [3:0]    o_status
);

  localparam logic [M:0] M_LIMIT = (M + 1)'(M);

  shift_state_e  state_q;
  shift_mode_e   mode_q;
  logic [M-1:0]  data_q;
  logic [CW-1:0] cnt_q;

  logic [M-1:0]  operand;
  logic [M-1:0]  shifted;
  logic [M-1:0]  calc_in;
  logic [2:1]    flags;
  logic          b_neg;
  logic          b_range;
  logic          b_zero;

`ifdef ITER_SHIFT_INVERT_EN
  assign operand = i_inv ? ~i_arg_A : i_arg_A;
`else
  assign operand = i_arg_A;
`endif

  assign b_neg   = i_arg_B[M-1];
  assign b_range = !b_neg && ({1'b0, i_arg_B} >= M_LIMIT);
  assign b_zero  = (i_arg_B == '0);

  function automatic logic [M-1:0] shift_once(input logic [M-1:0] d, input shift_mode_e m);
    case (m)
      LSR:     return {1'b0, d[M-1:1]};
      ASR:     return {d[M-1], d[M-1:1]};
      LSL:     return {d[M-2:0], 1'b0};
      default: return {d[0], d[M-1:1]};
    endcase
  endfunction

  assign shifted = shift_once(data_q, mode_q);

  // B == 0 finishes straight from IDLE, so the flag calculator must see the raw operand there.
  assign calc_in = (state_q == IDLE) ? operand : shifted;

  shift_status_calc #(.M(M)) u_status (
    .result (calc_in),
    .flags  (flags)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mode_q   <= LSR;
      data_q   <= '0;
      cnt_q    <= '0;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_newA   <= '0;
      o_status <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            data_q  <= operand;
            mode_q  <= shift_mode_e'(i_mode);
            cnt_q   <= i_arg_B[CW-1:0];
            o_ready <= 1'b0;
            if (b_neg) begin
              state_q  <= DONE;
              o_valid  <= 1'b1;
              o_newA   <= '0;
              o_status <= pack_status(1'b1, 1'b0, 1'b0, 1'b0);
            end else if (b_range) begin
              state_q  <= DONE;
              o_valid  <= 1'b1;
              o_newA   <= '0;
              o_status <= pack_status(1'b0, 1'b0, 1'b0, 1'b1);
            end else if (b_zero) begin
              state_q  <= DONE;
              o_valid  <= 1'b1;
              o_newA   <= operand;
              o_status <= pack_status(1'b0, flags[ST_PAR], flags[ST_ONES], 1'b0);
            end else begin
              state_q <= SHIFT;
            end
          end
        end

        SHIFT: begin
          data_q <= shifted;
          cnt_q  <= cnt_q - CW'(1);
          // A count of 1 means this edge performs the final shift.
          if (cnt_q == CW'(1)) begin
            state_q  <= DONE;
            o_valid  <= 1'b1;
            o_newA   <= shifted;
            o_status <= pack_status(1'b0, flags[ST_PAR], flags[ST_ONES], 1'b0);
          end
        end

        DONE: begin
          if (i_ready) begin
            state_q  <= IDLE;
            o_valid  <= 1'b0;
            o_newA   <= '0;
            o_status <= '0;
            o_ready  <= 1'b1;
          end
        end

        default: begin
          state_q  <= IDLE;
          o_valid  <= 1'b0;
          o_newA   <= '0;
          o_status <= '0;
          o_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Table-driven bench with a scoreboard queue for iter_shift_unit (M = 8).
// Covers the inversion path too when ITER_SHIFT_INVERT_EN is defined.
module tb_iter_shift_unit;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [M-1:0] i_arg_A;
  logic [M-1:0] i_arg_B;
  logic [1:0]   i_mode;
`ifdef ITER_SHIFT_INVERT_EN
  logic         i_inv;
`endif
  logic         o_valid;
  logic         i_ready;
  logic [M-1:0] o_newA;
  logic [3:0]   o_status;

  always #5 clk = ~clk;

  iter_shift_unit #(.M(M)) dut (
    .i_clk    (clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .i_mode   (i_mode),
`ifdef ITER_SHIFT_INVERT_EN
    .i_inv    (i_inv),
`endif
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_newA   (o_newA),
    .o_status (o_status)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       inv;
    logic [7:0] exp_a;
    logic [3:0] exp_st;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [3:0] st;
    int         lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Accept-edge-to-valid latency: 1 for error/zero cases, B+1 for real shifts.
  function automatic int exp_latency(input logic [7:0] b);
    if (b[7] || b >= 8'd8 || b == 8'd0) return 1;
    return int'(b) + 1;
  endfunction

  // Drives one request and leaves the bench 1 time unit after the accept edge.
  task automatic applyStimulus(input vec_t v, input bit push);
    int guard = 0;
    exp_t e;
    @(negedge clk);
    while (!o_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({v.name, "_ready_wait"}, o_ready, 1);
    i_valid = 1'b1;
    i_mode  = v.mode;
    i_arg_A = v.a;
    i_arg_B = v.b;
`ifdef ITER_SHIFT_INVERT_EN
    i_inv   = v.inv;
`endif
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (push) begin
      e.a   = v.exp_a;
      e.st  = v.exp_st;
      e.lat = exp_latency(v.b);
      sb.push_back(e);
    end
  endtask

  // Waits for o_valid while driving ignored garbage, optionally stalls, then completes the handshake.
  task automatic checkOutput(input string name, input int hold);
    int   lat = 1;
    exp_t e;
    while (!o_valid && lat < 64) begin
      i_valid = 1'b1;
      i_arg_A = 8'($urandom);
      i_arg_B = 8'($urandom_range(1, 7));
      i_mode  = 2'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
      e.a = '0; e.st = '0; e.lat = 0;
    end else begin
      e = sb.pop_front();
    end
    check({name, "_latency"}, lat, e.lat);
    check({name, "_newA"}, o_newA, e.a);
    check({name, "_status"}, o_status, e.st);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, o_valid, 1);
      check({name, "_hold_newA"}, o_newA, e.a);
      check({name, "_hold_status"}, o_status, e.st);
      check({name, "_hold_ready"}, o_ready, 0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({name, "_after_ready"}, o_ready, 1);
    check({name, "_after_valid"}, o_valid, 0);
    check({name, "_after_newA"}, o_newA, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   seen;

    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_arg_A = '0;
    i_arg_B = '0;
    i_mode  = '0;
`ifdef ITER_SHIFT_INVERT_EN
    i_inv   = 1'b0;
`endif
    #2 i_rst_n = 1'b0;
    #1;
    check("reset_ready", o_ready, 1);
    check("reset_valid", o_valid, 0);
    check("reset_newA", o_newA, 0);
    check("reset_status", o_status, 0);
    @(negedge clk);
    i_rst_n = 1'b1;

    vecs.push_back('{"lsr_b4_2",    2'b00, 8'hB4, 8'd2,   1'b0, 8'h2D, 4'b0010});
    vecs.push_back('{"asr_80_7",    2'b01, 8'h80, 8'd7,   1'b0, 8'hFF, 4'b0110});
    vecs.push_back('{"neg_b",       2'b00, 8'h5A, 8'hFF,  1'b0, 8'h00, 4'b0001});
    vecs.push_back('{"lsl_range",   2'b10, 8'hFF, 8'd8,   1'b0, 8'h00, 4'b1000});
    vecs.push_back('{"ror_01_1",    2'b11, 8'h01, 8'd1,   1'b0, 8'h80, 4'b0000});
    vecs.push_back('{"lsl_03_1",    2'b10, 8'h03, 8'd1,   1'b0, 8'h06, 4'b0010});
    vecs.push_back('{"asr_b0",      2'b01, 8'hC3, 8'd0,   1'b0, 8'hC3, 4'b0010});
    vecs.push_back('{"ror_81_4",    2'b11, 8'h81, 8'd4,   1'b0, 8'h18, 4'b0010});
    vecs.push_back('{"ror_range",   2'b11, 8'hAA, 8'd8,   1'b0, 8'h00, 4'b1000});
    vecs.push_back('{"asr_7f_3",    2'b01, 8'h7F, 8'd3,   1'b0, 8'h0F, 4'b0010});
    vecs.push_back('{"lsr_01_1",    2'b00, 8'h01, 8'd1,   1'b0, 8'h00, 4'b0000});
    vecs.push_back('{"lsl_01_7",    2'b10, 8'h01, 8'd7,   1'b0, 8'h80, 4'b0000});
    vecs.push_back('{"ones_b0",     2'b00, 8'hFF, 8'd0,   1'b0, 8'hFF, 4'b0110});
    vecs.push_back('{"asr_b4_4",    2'b01, 8'hB4, 8'd4,   1'b0, 8'hFB, 4'b0000});
    vecs.push_back('{"ror_neg128",  2'b11, 8'h3C, 8'h80,  1'b0, 8'h00, 4'b0001});
    vecs.push_back('{"lsr_b127",    2'b00, 8'h3C, 8'h7F,  1'b0, 8'h00, 4'b1000});
`ifdef ITER_SHIFT_INVERT_EN
    vecs.push_back('{"inv_lsr_0f",  2'b00, 8'h0F, 8'd4,   1'b1, 8'h0F, 4'b0010});
    vecs.push_back('{"inv_b0",      2'b10, 8'h00, 8'd0,   1'b1, 8'hFF, 4'b0110});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], 1'b1);
      checkOutput(vecs[i].name, 0);
    end

    // Consumer stalls for three cycles; outputs must hold and o_ready stay low.
    v = '{"ror_hold", 2'b11, 8'h01, 8'd1, 1'b0, 8'h80, 4'b0000};
    applyStimulus(v, 1'b1);
    checkOutput(v.name, 3);

    // Reset two cycles into a 5-step shift must abort it without a result.
    v = '{"lsl_abort", 2'b10, 8'h03, 8'd5, 1'b0, 8'h00, 4'b0000};
    applyStimulus(v, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("abort_valid", o_valid, 0);
    check("abort_newA", o_newA, 0);
    check("abort_status", o_status, 0);
    check("abort_ready", o_ready, 1);
    @(negedge clk);
    i_rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    v = '{"lsl_after_rst", 2'b10, 8'h03, 8'd1, 1'b0, 8'h06, 4'b0010};
    applyStimulus(v, 1'b1);
    checkOutput(v.name, 0);

    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
